// File: rtl/updown_seq_pkg.sv
// Shared types and reset constants for the up/down sequencer and its counter core.
// Pure declarations: no latency, no flow control.
package updown_seq_pkg;

  localparam int unsigned RST_WIDTH = 3;
  localparam int unsigned RST_LO    = 1;
  localparam int unsigned RST_HI    = 7;

  typedef enum logic [1:0] {
    UP_WRAP   = 2'b00,
    DOWN_WRAP = 2'b01,
    BOUNCE    = 2'b10,
    ONESHOT   = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    UP   = 2'b01,
    DOWN = 2'b10
  } state_t;

  localparam mode_t RST_MODE = BOUNCE;

endpackage

// File: rtl/updown_seq_ctrl_if.sv
// Control/status bundle of the up/down sequencer; master drives config and run
// commands, slave returns count and status pulses. pause exists only with UPDOWN_SEQ_PAUSE_EN.
interface updown_seq_ctrl_if #(
  parameter int WIDTH = 3
);
  logic             cfg_wr;
  logic [WIDTH-1:0] cfg_lo;
  logic [WIDTH-1:0] cfg_hi;
  logic [1:0]       cfg_mode;
  logic             start;
  logic             stop;
`ifdef UPDOWN_SEQ_PAUSE_EN
  logic             pause;
`endif
  logic [WIDTH-1:0] count;
  logic             dir;
  logic             busy;
  logic             turn;
  logic             done;
  logic             cfg_err;

  modport master (
`ifdef UPDOWN_SEQ_PAUSE_EN
    output pause,
`endif
    output cfg_wr, cfg_lo, cfg_hi, cfg_mode, start, stop,
    input  count, dir, busy, turn, done, cfg_err
  );

  modport slave (
`ifdef UPDOWN_SEQ_PAUSE_EN
    input  pause,
`endif
    input  cfg_wr, cfg_lo, cfg_hi, cfg_mode, start, stop,
    output count, dir, busy, turn, done, cfg_err
  );

endinterface

// File: rtl/updown_cnt_core.sv
// Counter register with load priority over step; one-cycle update, no backpressure.
// Step direction and enable come entirely from the sequencer.
module updown_cnt_core
  import updown_seq_pkg::*;
#(
  parameter int WIDTH   = RST_WIDTH,
  parameter int RST_VAL = RST_LO
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_val,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] count_q;

  always_comb begin
    count_d = count_q;
    if (ld) begin
      count_d = ld_val;
    end else if (en) begin
      count_d = up ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= WIDTH'(RST_VAL);
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/updown_seq_ctrl.sv
// Bounded up/down counter sequencer: every command takes effect on the next edge, status
// pulses are registered; no backpressure. UPDOWN_SEQ_PAUSE_EN adds a pause input that freezes a run.
module updown_seq_ctrl
  import updown_seq_pkg::*;
#(
  parameter int WIDTH      = RST_WIDTH,
  parameter int DEFAULT_LO = RST_LO,
  parameter int DEFAULT_HI = RST_HI
) (
  input  logic              clk,
  input  logic              rst,
  updown_seq_ctrl_if.slave  io
);

  state_t           state_d, state_q;
  mode_t            mode_d, mode_q;
  logic [WIDTH-1:0] lo_d, lo_q;
  logic [WIDTH-1:0] hi_d, hi_q;
  logic             dir_d, dir_q;
  logic             busy_d, busy_q;
  logic             turn_d, turn_q;
  logic             done_d, done_q;
  logic             cfg_err_d, cfg_err_q;

  logic             cnt_ld;
  logic             cnt_en;
  logic             cnt_up;
  logic [WIDTH-1:0] cnt_ld_val;
  logic [WIDTH-1:0] count;
  logic             pause;

`ifdef UPDOWN_SEQ_PAUSE_EN
  assign pause = io.pause;
`else
  assign pause = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    lo_d       = lo_q;
    hi_d       = hi_q;
    dir_d      = dir_q;
    busy_d     = busy_q;
    turn_d     = 1'b0;
    done_d     = 1'b0;
    cfg_err_d  = 1'b0;
    cnt_ld     = 1'b0;
    cnt_en     = 1'b0;
    cnt_up     = dir_q;
    cnt_ld_val = lo_q;

    case (state_q)
      IDLE: begin
        if (io.cfg_wr) begin
          if (io.cfg_lo < io.cfg_hi) begin
            lo_d   = io.cfg_lo;
            hi_d   = io.cfg_hi;
            mode_d = mode_t'(io.cfg_mode);
          end else begin
            cfg_err_d = 1'b1;
          end
        end
        // A start alongside a cfg write still runs with the old limits.
        if (io.start) begin
          busy_d = 1'b1;
          cnt_ld = 1'b1;
          if (mode_q == DOWN_WRAP) begin
            cnt_ld_val = hi_q;
            dir_d      = 1'b0;
            state_d    = DOWN;
          end else begin
            cnt_ld_val = lo_q;
            dir_d      = 1'b1;
            state_d    = UP;
          end
        end
      end

      UP, DOWN: begin
        cfg_err_d = io.cfg_wr;
        if (io.stop) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else if (!pause) begin
          if (state_q == UP) begin
            if (count < hi_q) begin
              cnt_en = 1'b1;
              cnt_up = 1'b1;
            end else if (mode_q == BOUNCE) begin
              cnt_ld     = 1'b1;
              cnt_ld_val = hi_q - WIDTH'(1);
              dir_d      = 1'b0;
              state_d    = DOWN;
              turn_d     = 1'b1;
            end else if (mode_q == ONESHOT) begin
              state_d = IDLE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end else begin
              cnt_ld     = 1'b1;
              cnt_ld_val = lo_q;
              turn_d     = 1'b1;
            end
          end else begin
            if (count > lo_q) begin
              cnt_en = 1'b1;
              cnt_up = 1'b0;
            end else if (mode_q == BOUNCE) begin
              cnt_ld     = 1'b1;
              cnt_ld_val = lo_q + WIDTH'(1);
              dir_d      = 1'b1;
              state_d    = UP;
              turn_d     = 1'b1;
            end else begin
              cnt_ld     = 1'b1;
              cnt_ld_val = hi_q;
              turn_d     = 1'b1;
            end
          end
        end
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      mode_q    <= RST_MODE;
      lo_q      <= WIDTH'(DEFAULT_LO);
      hi_q      <= WIDTH'(DEFAULT_HI);
      dir_q     <= 1'b1;
      busy_q    <= 1'b0;
      turn_q    <= 1'b0;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      lo_q      <= lo_d;
      hi_q      <= hi_d;
      dir_q     <= dir_d;
      busy_q    <= busy_d;
      turn_q    <= turn_d;
      done_q    <= done_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  updown_cnt_core #(
    .WIDTH   (WIDTH),
    .RST_VAL (DEFAULT_LO)
  ) u_core (
    .clk    (clk),
    .rst    (rst),
    .ld     (cnt_ld),
    .ld_val (cnt_ld_val),
    .en     (cnt_en),
    .up     (cnt_up),
    .count  (count)
  );

  assign io.count   = count;
  assign io.dir     = dir_q;
  assign io.busy    = busy_q;
  assign io.turn    = turn_q;
  assign io.done    = done_q;
  assign io.cfg_err = cfg_err_q;

endmodule

// File: tb/tb_updown_seq_ctrl.sv
// Directed vector bench for updown_seq_ctrl (WIDTH=3, lo/hi defaults 1/7).
// Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
module tb_updown_seq_ctrl;

  localparam int W = 3;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  updown_seq_ctrl_if #(.WIDTH(W)) bus ();

  updown_seq_ctrl #(
    .WIDTH      (W),
    .DEFAULT_LO (1),
    .DEFAULT_HI (7)
  ) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  typedef struct packed {
    logic [W-1:0] count;
    logic         dir;
    logic         busy;
    logic         turn;
    logic         done;
    logic         cfg_err;
  } out_t;

  typedef struct {
    logic         cfg_wr;
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic [1:0]   mode;
    logic         start;
    logic         stop;
    logic         pause;
    out_t         exp;
  } vec_t;

  vec_t vecs[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  function automatic out_t o(int c, bit d, bit b, bit t = 0, bit dn = 0, bit e = 0);
    out_t r;
    r.count   = W'(c);
    r.dir     = d;
    r.busy    = b;
    r.turn    = t;
    r.done    = dn;
    r.cfg_err = e;
    return r;
  endfunction

  function automatic vec_t mk(bit cw, int lo, int hi, int md, bit st, bit sp, out_t e, bit pz = 0);
    vec_t v;
    v.cfg_wr = cw;
    v.lo     = W'(lo);
    v.hi     = W'(hi);
    v.mode   = 2'(md);
    v.start  = st;
    v.stop   = sp;
    v.pause  = pz;
    v.exp    = e;
    return v;
  endfunction

  task automatic add(bit cw, int lo, int hi, int md, bit st, bit sp, out_t e);
    vecs.push_back(mk(cw, lo, hi, md, st, sp, e));
  endtask

  task automatic run(int c, bit d, bit b, bit t = 0);
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, o(c, d, b, t)));
  endtask

  task automatic check(string name, out_t e);
    out_t a;
    a.count   = bus.count;
    a.dir     = bus.dir;
    a.busy    = bus.busy;
    a.turn    = bus.turn;
    a.done    = bus.done;
    a.cfg_err = bus.cfg_err;
    n_vec++;
    if (a !== e) begin
      n_miss++;
      $display("FAIL %s: got cnt=%0d dir=%0b busy=%0b turn=%0b done=%0b err=%0b, want cnt=%0d dir=%0b busy=%0b turn=%0b done=%0b err=%0b",
               name, a.count, a.dir, a.busy, a.turn, a.done, a.cfg_err,
               e.count, e.dir, e.busy, e.turn, e.done, e.cfg_err);
    end
  endtask

  task automatic apply(vec_t v, string name);
    @(negedge clk);
    bus.cfg_wr   = v.cfg_wr;
    bus.cfg_lo   = v.lo;
    bus.cfg_hi   = v.hi;
    bus.cfg_mode = v.mode;
    bus.start    = v.start;
    bus.stop     = v.stop;
`ifdef UPDOWN_SEQ_PAUSE_EN
    bus.pause    = v.pause;
`endif
    @(posedge clk);
    #1;
    check(name, v.exp);
  endtask

  initial begin
    rst          = 1'b1;
    bus.cfg_wr   = 1'b0;
    bus.cfg_lo   = '0;
    bus.cfg_hi   = '0;
    bus.cfg_mode = 2'b00;
    bus.start    = 1'b0;
    bus.stop     = 1'b0;
`ifdef UPDOWN_SEQ_PAUSE_EN
    bus.pause    = 1'b0;
`endif

    // Rejected config (lo > hi) must leave limits 1/7 and bounce mode in place.
    add(1, 5, 3, 0, 0, 0, o(1, 1, 0, 0, 0, 1));
    run(1, 1, 0);
    // Bounce run; one start while busy is ignored.
    add(0, 0, 0, 0, 1, 0, o(1, 1, 1));
    run(2, 1, 1);
    run(3, 1, 1);
    add(0, 0, 0, 0, 1, 0, o(4, 1, 1));
    for (int c = 5; c <= 7; c++) run(c, 1, 1);
    run(6, 0, 1, 1);
    for (int c = 5; c >= 1; c--) run(c, 0, 1);
    run(2, 1, 1, 1);
    run(3, 1, 1);
    add(1, 2, 5, 0, 0, 0, o(4, 1, 1, 0, 0, 1));
    for (int c = 5; c <= 7; c++) run(c, 1, 1);
    // Stop at hi in bounce: stop wins, no turn.
    add(0, 0, 0, 0, 0, 1, o(7, 1, 0, 0, 1));
    run(7, 1, 0);
    // One-shot 2..4.
    add(1, 2, 4, 3, 0, 0, o(7, 1, 0));
    add(0, 0, 0, 0, 1, 0, o(2, 1, 1));
    run(3, 1, 1);
    run(4, 1, 1);
    add(0, 0, 0, 0, 0, 0, o(4, 1, 0, 0, 1));
    run(4, 1, 0);
    // Up-wrap 0..7, then stop at 5.
    add(1, 0, 7, 0, 0, 0, o(4, 1, 0));
    add(0, 0, 0, 0, 1, 0, o(0, 1, 1));
    for (int c = 1; c <= 7; c++) run(c, 1, 1);
    run(0, 1, 1, 1);
    for (int c = 1; c <= 5; c++) run(c, 1, 1);
    add(0, 0, 0, 0, 0, 1, o(5, 1, 0, 0, 1));
    run(5, 1, 0);
    // Down-wrap 7..0.
    add(1, 0, 7, 1, 0, 0, o(5, 1, 0));
    add(0, 0, 0, 0, 1, 0, o(7, 0, 1));
    for (int c = 6; c >= 0; c--) run(c, 0, 1);
    run(7, 0, 1, 1);
    run(6, 0, 1);
    add(0, 0, 0, 0, 0, 1, o(6, 0, 0, 0, 1));

    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset", o(1, 1, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i], $sformatf("vec%0d", i));
    end

    // Async reset between edges, mid down-wrap run.
    apply(mk(0, 0, 0, 0, 1, 0, o(7, 0, 1)), "rst_run0");
    apply(mk(0, 0, 0, 0, 0, 0, o(6, 0, 1)), "rst_run1");
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("async_rst", o(1, 1, 0));
    @(negedge clk);
    rst = 1'b0;
    apply(mk(0, 0, 0, 0, 0, 0, o(1, 1, 0)), "post_rst_no_done");

`ifdef UPDOWN_SEQ_PAUSE_EN
    apply(mk(0, 0, 0, 0, 1, 0, o(1, 1, 1)), "pz_start");
    for (int c = 2; c <= 4; c++) apply(mk(0, 0, 0, 0, 0, 0, o(c, 1, 1)), $sformatf("pz_run%0d", c));
    for (int k = 0; k < 3; k++) apply(mk(0, 0, 0, 0, 0, 0, o(4, 1, 1), 1), $sformatf("pz_hold%0d", k));
    apply(mk(0, 0, 0, 0, 0, 0, o(5, 1, 1)), "pz_resume");
    apply(mk(0, 0, 0, 0, 0, 1, o(5, 1, 0, 0, 1), 1), "pz_stop");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
